// File: rtl/resamp_pkg.sv
// rtl/resamp_pkg.sv - shared defaults, state encoding and helpers for the polyphase resampler
//
// Purpose: default parameter values for the tap buffer, its two-state
// FSM encoding, and a constant clog2 used to size stream counters.
// Ports: none (package).

package resamp_pkg;

    localparam int DWIDTH_DEF     = 16;
    localparam int NR_STREAMS_DEF = 16;
    localparam int NR_TAPS_DEF    = 4;
    localparam int L_DEF          = 160;
    localparam int M_DEF          = 147;
    localparam int PHASE_BITS_DEF = 8;

    // LOAD gathers one input frame, EMIT streams the tap windows out.
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/resamp_phase_acc.sv
// rtl/resamp_phase_acc.sv - L/M phase accumulator deciding consume versus re-emit
//
// Purpose: holds the coefficient phase. Each output frame end (step) adds M;
// when the sum reaches L the phase wraps by L and a new input frame is needed.
// Ports:
//   clk, rst   clock, synchronous active-high reset (acc cleared)
//   step       end-of-output-frame strobe
//   acc        current phase, 0..L-1
//   shift_req  acc+M >= L, i.e. the frame ending now must be followed by a load

module resamp_phase_acc
    import resamp_pkg::*;
#(
    parameter int L          = L_DEF,
    parameter int M          = M_DEF,
    parameter int PHASE_BITS = PHASE_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    output logic [PHASE_BITS-1:0] acc,
    output logic                  shift_req
);

    // One extra bit so acc+M never overflows before the compare against L.
    logic [PHASE_BITS:0] sum;

    assign sum       = {1'b0, acc} + (PHASE_BITS + 1)'(M);
    assign shift_req = (sum >= (PHASE_BITS + 1)'(L));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (step) begin
            if (shift_req) begin
                acc <= PHASE_BITS'(sum - (PHASE_BITS + 1)'(L));
            end else begin
                acc <= sum[PHASE_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/polyphase_tap_buffer.sv
// rtl/polyphase_tap_buffer.sv - multi-stream tap window buffer feeding the polyphase MAC
//
// Purpose: collects round-robin interleaved samples into per-stream delay
// lines and emits every stream's tap window together with the coefficient
// phase; the phase accumulator decides when a fresh input frame is consumed.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_in/ack_in       sample handshake, data_in taken when both high
//   data_in             sample for the stream currently being filled
//   req_out/ack_out     window handshake, word retired when both high
//   data_out            window[out_stream], tap t at [t*DWIDTH +: DWIDTH], tap 0 newest
//   out_stream          stream index of data_out
//   out_phase           coefficient phase for this output frame

module polyphase_tap_buffer
    import resamp_pkg::*;
#(
    parameter int DWIDTH         = DWIDTH_DEF,
    parameter int NR_STREAMS     = NR_STREAMS_DEF,
    parameter int NR_STREAMS_LOG = clog2(NR_STREAMS_DEF),
    parameter int NR_TAPS        = NR_TAPS_DEF,
    parameter int L              = L_DEF,
    parameter int M              = M_DEF,
    parameter int PHASE_BITS     = PHASE_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      req_in,
    input  logic                      ack_in,
    input  logic [DWIDTH-1:0]         data_in,
    output logic                      req_out,
    input  logic                      ack_out,
    output logic [NR_TAPS*DWIDTH-1:0] data_out,
    output logic [NR_STREAMS_LOG-1:0] out_stream,
    output logic [PHASE_BITS-1:0]     out_phase
);

    localparam logic [NR_STREAMS_LOG-1:0] LAST_STREAM = NR_STREAMS_LOG'(NR_STREAMS - 1);

    logic [0:0]                state;
    logic                      live;
    logic [NR_STREAMS_LOG-1:0] in_cnt;
    logic [DWIDTH-1:0]         win [NR_STREAMS][NR_TAPS];

    logic in_xfer;
    logic out_xfer;
    logic in_last;
    logic out_last;
    logic shift_req;

    // live keeps req_in low while rst is held even though state already reads LOAD.
    assign req_in   = live && (state == ST_LOAD);
    assign req_out  = live && (state == ST_EMIT);
    assign in_xfer  = req_in && ack_in;
    assign out_xfer = req_out && ack_out;
    assign in_last  = in_xfer && (in_cnt == LAST_STREAM);
    assign out_last = out_xfer && (out_stream == LAST_STREAM);

    resamp_phase_acc #(
        .L          (L),
        .M          (M),
        .PHASE_BITS (PHASE_BITS)
    ) u_phase_acc (
        .clk       (clk),
        .rst       (rst),
        .step      (out_last),
        .acc       (out_phase),
        .shift_req (shift_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            live       <= 1'b0;
            in_cnt     <= '0;
            out_stream <= '0;
            for (int s = 0; s < NR_STREAMS; s++) begin
                for (int t = 0; t < NR_TAPS; t++) begin
                    win[s][t] <= '0;
                end
            end
        end else begin
            live <= 1'b1;

            if (in_xfer) begin
                for (int t = NR_TAPS - 1; t > 0; t--) begin
                    win[in_cnt][t] <= win[in_cnt][t-1];
                end
                win[in_cnt][0] <= data_in;
                in_cnt <= in_last ? '0 : in_cnt + NR_STREAMS_LOG'(1);
                if (in_last) begin
                    state <= ST_EMIT;
                end
            end

            if (out_xfer) begin
                out_stream <= out_last ? '0 : out_stream + NR_STREAMS_LOG'(1);
                // Without a shift the same windows go out again at the new phase.
                if (out_last && shift_req) begin
                    state <= ST_LOAD;
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int t = 0; t < NR_TAPS; t++) begin
            data_out[t*DWIDTH +: DWIDTH] = win[out_stream][t];
        end
    end

endmodule

// File: tb/tb_polyphase_tap_buffer.sv
// tb/tb_polyphase_tap_buffer.sv - directed self-checking bench for polyphase_tap_buffer

module tb_polyphase_tap_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack_in = 1'b0;
    logic        ack_out = 1'b0;
    logic [15:0] data_in = '0;
    logic        req_in;
    logic        req_out;
    logic [63:0] data_out;
    logic [3:0]  out_stream;
    logic [7:0]  out_phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    polyphase_tap_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .ack_in     (ack_in),
        .data_in    (data_in),
        .req_out    (req_out),
        .ack_out    (ack_out),
        .data_out   (data_out),
        .out_stream (out_stream),
        .out_phase  (out_phase)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req_in();
        int n;
        n = 0;
        while (req_in !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("req_in_timeout", 64'(req_in), 64'd1);
    endtask

    task automatic wait_req_out();
        int n;
        n = 0;
        while (req_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("req_out_timeout", 64'(req_out), 64'd1);
    endtask

    // Sample s of the frame carries base + step*s; acked on consecutive cycles.
    task automatic send_samples(input logic [15:0] base, input logic [15:0] step, input int n);
        for (int s = 0; s < n; s++) begin
            wait_req_in();
            ack_in  = 1'b1;
            data_in = base + step * 16'(s);
            @(negedge clk);
        end
        ack_in = 1'b0;
    endtask

    task automatic recv_frame(input logic [7:0] exp_phase, input int chk_s,
                              input logic [63:0] chk_d, input int bp_s);
        for (int s = 0; s < 16; s++) begin
            wait_req_out();
            check("out_stream", 64'(out_stream), 64'(s));
            check("out_phase", 64'(out_phase), 64'(exp_phase));
            if (s == chk_s) check("data_out", data_out, chk_d);
            if (s == bp_s) begin
                ack_out = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_req_out", 64'(req_out), 64'd1);
                    check("bp_req_in", 64'(req_in), 64'd0);
                    check("bp_stream", 64'(out_stream), 64'(s));
                    check("bp_phase", 64'(out_phase), 64'(exp_phase));
                    check("bp_data", data_out, chk_d);
                end
            end
            ack_out = 1'b1;
            @(negedge clk);
        end
        ack_out = 1'b0;
    endtask

    initial begin
        int model_acc;
        int sum;
        int out_frames;
        int in_xfers;
        int cyc;
        logic done;

        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_in", 64'(req_in), 64'd0);
        check("rst_req_out", 64'(req_out), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_out_phase", 64'(out_phase), 64'd0);
        check("rst_out_stream", 64'(out_stream), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_in", 64'(req_in), 64'd1);
        check("post_rst_req_out", 64'(req_out), 64'd0);

        // First frame 0x0001..0x0010
        send_samples(16'h0001, 16'h0001, 16);
        check("first_req_out", 64'(req_out), 64'd1);
        check("first_req_in", 64'(req_in), 64'd0);
        check("first_data_s0", data_out, 64'h0000_0000_0000_0001);
        check("first_phase", 64'(out_phase), 64'd0);

        // Backpressure at stream 7, then the re-emit at phase 147
        recv_frame(8'd0, 7, 64'h0000_0000_0000_0008, 7);
        recv_frame(8'd147, 0, 64'h0000_0000_0000_0001, -1);

        // Five frames, one output frame each; stream s sample = (s<<4)+j
        for (int j = 0; j < 5; j++) begin
            send_samples(16'(j), 16'h0010, 16);
            if (j == 0)
                recv_frame(8'd134, 1, 64'h0000_0000_0002_0010, -1);
            else if (j == 4)
                recv_frame(8'd82, 3, 64'h0031_0032_0033_0034, -1);
            else
                recv_frame(8'(134 - 13 * j), -1, 64'd0, -1);
        end

        // Reset in the middle of a load
        send_samples(16'hAAAA, 16'h0000, 7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_req_in", 64'(req_in), 64'd0);
        check("mid_rst_req_out", 64'(req_out), 64'd0);
        check("mid_rst_data", data_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_req_in", 64'(req_in), 64'd1);
        check("mid_post_phase", 64'(out_phase), 64'd0);
        check("mid_post_stream", 64'(out_stream), 64'd0);

        send_samples(16'h0100, 16'h0001, 16);
        check("restart_req_out", 64'(req_out), 64'd1);
        check("restart_data_s0", data_out, 64'h0000_0000_0000_0100);
        check("restart_phase", 64'(out_phase), 64'd0);

        // Free-running rate check over 160 output frames
        model_acc  = 0;
        out_frames = 0;
        in_xfers   = 16;
        cyc        = 0;
        done       = 1'b0;
        ack_in     = 1'b1;
        ack_out    = 1'b1;
        while (!done && cyc < 10000) begin
            if (out_frames == 160) begin
                ack_out = 1'b0;
                if (req_out) done = 1'b1;
            end
            if (!done) begin
                if (req_in && ack_in) in_xfers++;
                if (req_out && ack_out) begin
                    if (out_stream == 4'd0)
                        check("rate_phase", 64'(out_phase), 64'(model_acc));
                    if (out_frames == 0 && out_stream == 4'd6)
                        check("cleared_s6", data_out, 64'h0000_0000_0000_0106);
                    if (out_stream == 4'd15) begin
                        out_frames++;
                        sum = model_acc + 147;
                        model_acc = (sum >= 160) ? sum - 160 : sum;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        ack_in  = 1'b0;
        ack_out = 1'b0;
        check("rate_done", 64'(done), 64'd1);
        check("rate_out_frames", 64'(out_frames), 64'd160);
        check("rate_in_samples", 64'(in_xfers), 64'(148 * 16));
        check("rate_acc_wrap", 64'(out_phase), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
